// File: rtl/cfu_mac_sequencer.sv
// cfu_mac_sequencer: upstream driver for the multiply/accumulate CFU.
// Turns a packet of 32-bit operand pairs (terminated by in_last) into one
// clear command followed by one MAC command per pair, keeping exactly one CFU
// command outstanding, and returns the final accumulator and beat count.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          operand pair handshake (in_a, in_b, in_last)
//   cfu_cmd_valid/ready        CFU command handshake (function_id, inputs_0/1)
//   cfu_rsp_valid/ready        CFU response handshake (outputs_0)
//   out_valid/out_ready        job result handshake (out_result, out_count)
//   err_unexpected_rsp         sticky flag: CFU response outside a wait state
module cfu_mac_sequencer #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [9:0]  FID_CLEAR = 10'h00B,
    parameter logic [9:0]  FID_MAC   = 10'h003
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              in_last,
    output logic              cfu_cmd_valid,
    input  logic              cfu_cmd_ready,
    output logic [9:0]        cfu_cmd_function_id,
    output logic [31:0]       cfu_cmd_inputs_0,
    output logic [31:0]       cfu_cmd_inputs_1,
    input  logic              cfu_rsp_valid,
    output logic              cfu_rsp_ready,
    input  logic [31:0]       cfu_rsp_outputs_0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [CNT_W-1:0]  out_count,
    output logic              err_unexpected_rsp
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR_ISSUE = 3'd1,
        CLR_WAIT  = 3'd2,
        FETCH     = 3'd3,
        MAC_ISSUE = 3'd4,
        MAC_WAIT  = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  beat_cnt;
    logic              last_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (in_valid)      state_n = CLR_ISSUE;
            CLR_ISSUE: if (cfu_cmd_ready) state_n = CLR_WAIT;
            CLR_WAIT:  if (cfu_rsp_valid) state_n = FETCH;
            FETCH:     if (in_valid)      state_n = MAC_ISSUE;
            MAC_ISSUE: if (cfu_cmd_ready) state_n = MAC_WAIT;
            MAC_WAIT:  if (cfu_rsp_valid) state_n = last_q ? DONE : FETCH;
            DONE:      if (out_ready)     state_n = IDLE;
            default:                      state_n = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so each one is a pure
    // function of the current state with no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready      <= 1'b0;
            cfu_cmd_valid <= 1'b0;
            cfu_rsp_ready <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            in_ready      <= (state_n == FETCH);
            cfu_cmd_valid <= (state_n == CLR_ISSUE) || (state_n == MAC_ISSUE);
            cfu_rsp_ready <= (state_n == CLR_WAIT)  || (state_n == MAC_WAIT);
            out_valid     <= (state_n == DONE);
        end
    end

    // Command payload, beat counter and result capture. The payload is only
    // written on the transitions into an ISSUE state, so it stays frozen
    // for as long as cfu_cmd_valid is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfu_cmd_function_id <= '0;
            cfu_cmd_inputs_0    <= '0;
            cfu_cmd_inputs_1    <= '0;
            last_q              <= 1'b0;
            beat_cnt            <= '0;
            out_result          <= '0;
            out_count           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (in_valid) begin
                        cfu_cmd_function_id <= FID_CLEAR;
                        cfu_cmd_inputs_0    <= '0;
                        cfu_cmd_inputs_1    <= '0;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        cfu_cmd_function_id <= FID_MAC;
                        cfu_cmd_inputs_0    <= in_a;
                        cfu_cmd_inputs_1    <= in_b;
                        last_q              <= in_last;
                        // Saturate rather than wrap
                        if (beat_cnt != {CNT_W{1'b1}}) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                MAC_WAIT: begin
                    if (cfu_rsp_valid && last_q) begin
                        out_result <= cfu_rsp_outputs_0;
                        out_count  <= beat_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky protocol error: a response arriving while no command is pending
    always_ff @(posedge clk) begin
        if (reset) begin
            err_unexpected_rsp <= 1'b0;
        end else if (cfu_rsp_valid && (state != CLR_WAIT) && (state != MAC_WAIT)) begin
            err_unexpected_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Directed testbench for cfu_mac_sequencer with a behavioural CFU responder.
module tb_cfu_mac_sequencer;

    localparam int unsigned TB_CNT_W = 3;
    localparam logic [9:0]  FID_CLR  = 10'h00B;
    localparam logic [9:0]  FID_MUL  = 10'h003;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_a;
    logic [31:0]          in_b;
    logic                 in_last;
    logic                 cfu_cmd_valid;
    logic                 cfu_cmd_ready;
    logic [9:0]           fid;
    logic [31:0]          cin0;
    logic [31:0]          cin1;
    logic                 rsp_valid_m;
    logic                 spur;
    logic                 cfu_rsp_ready;
    logic [31:0]          cfu_rsp_outputs_0;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_result;
    logic [TB_CNT_W-1:0]  out_count;
    logic                 err;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cmd_stall = 0;
    int          rsp_delay = 0;
    bit          abort = 1'b0;
    logic [73:0] cmd_log[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] acc;

    cfu_mac_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_a                (in_a),
        .in_b                (in_b),
        .in_last             (in_last),
        .cfu_cmd_valid       (cfu_cmd_valid),
        .cfu_cmd_ready       (cfu_cmd_ready),
        .cfu_cmd_function_id (fid),
        .cfu_cmd_inputs_0    (cin0),
        .cfu_cmd_inputs_1    (cin1),
        .cfu_rsp_valid       (rsp_valid_m | spur),
        .cfu_rsp_ready       (cfu_rsp_ready),
        .cfu_rsp_outputs_0   (cfu_rsp_outputs_0),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_result          (out_result),
        .out_count           (out_count),
        .err_unexpected_rsp  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CFU: accepts a command after cmd_stall cycles, answers after rsp_delay
    initial begin : cfu_model
        logic [9:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          guard;
        cfu_cmd_ready     = 1'b0;
        rsp_valid_m       = 1'b0;
        cfu_rsp_outputs_0 = '0;
        acc               = '0;
        forever begin
            @(negedge clk);
            if (cfu_cmd_valid === 1'b1 && !abort) begin
                f = fid; a = cin0; b = cin1;
                for (int i = 0; i < cmd_stall && !abort; i++) begin
                    @(negedge clk);
                    if (!abort) begin
                        n_cmp++;
                        if ({cfu_cmd_valid, fid, cin0, cin1} !== {1'b1, f, a, b}) begin
                            n_err++;
                            $display("FAIL cmd_hold: got v=%0b fid=%0h a=%0h b=%0h want v=1 fid=%0h a=%0h b=%0h",
                                     cfu_cmd_valid, fid, cin0, cin1, f, a, b);
                        end
                    end
                end
                if (!abort) begin
                    cfu_cmd_ready = 1'b1;
                    @(posedge clk);
                    #1 cfu_cmd_ready = 1'b0;
                    cmd_log.push_back({f, a, b});
                    if (f == FID_CLR) acc = '0;
                    else              acc = acc + a * b;
                    for (int i = 0; i < rsp_delay && !abort; i++) begin
                        @(negedge clk);
                        if (!abort) begin
                            n_cmp++;
                            if (cfu_cmd_valid !== 1'b0) begin
                                n_err++;
                                $display("FAIL one_outstanding: got cmd_valid=%0b want 0", cfu_cmd_valid);
                            end
                        end
                    end
                    if (!abort) begin
                        rsp_valid_m       = 1'b1;
                        cfu_rsp_outputs_0 = acc;
                        guard             = 0;
                        while (cfu_rsp_ready !== 1'b1 && guard < 200) begin
                            @(negedge clk);
                            guard++;
                        end
                        if (guard >= 200) begin
                            n_cmp++; n_err++;
                            $display("FAIL rsp_timeout: got rsp_ready=%0b want 1", cfu_rsp_ready);
                        end
                        @(posedge clk);
                        #1 rsp_valid_m = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
        int guard;
        guard    = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL in_accept_timeout: got in_ready=%0b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b1;   // stray last with valid low must be ignored
        @(negedge clk);
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp_res,
                               input logic [TB_CNT_W-1:0] exp_cnt);
        int guard;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (out_result !== exp_res) begin
            n_err++;
            $display("FAIL %s_result: got %0h want %0h", name, out_result, exp_res);
        end
        n_cmp++;
        if (out_count !== exp_cnt) begin
            n_err++;
            $display("FAIL %s_count: got %0d want %0d", name, out_count, exp_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_result} !== {1'b1, exp_res}) begin
                n_err++;
                $display("FAIL %s_hold: got valid=%0b result=%0h want valid=1 result=%0h",
                         name, out_valid, out_result, exp_res);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_release: got out_valid=%0b want 0", name, out_valid);
        end
    endtask

    // Drives qa/qb as one job, checks the result and the exact command sequence
    task automatic run_job(input string name, input logic [31:0] exp_res,
                           input logic [TB_CNT_W-1:0] exp_cnt);
        logic [73:0] exp_cmd;
        cmd_log.delete();
        for (int i = 0; i < qa.size(); i++) begin
            drive_pair(qa[i], qb[i], (i == qa.size() - 1));
        end
        wait_result(name, exp_res, exp_cnt);
        n_cmp++;
        if (cmd_log.size() != qa.size() + 1) begin
            n_err++;
            $display("FAIL %s_cmd_count: got %0d want %0d", name, cmd_log.size(), qa.size() + 1);
        end else begin
            for (int i = 0; i < cmd_log.size(); i++) begin
                exp_cmd = (i == 0) ? {FID_CLR, 32'h0, 32'h0} : {FID_MUL, qa[i-1], qb[i-1]};
                n_cmp++;
                if (cmd_log[i] !== exp_cmd) begin
                    n_err++;
                    $display("FAIL %s_cmd%0d: got %0h want %0h", name, i, cmd_log[i], exp_cmd);
                end
            end
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic add_pair(input logic [31:0] a, input logic [31:0] b);
        qa.push_back(a);
        qb.push_back(b);
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if ({in_ready, cfu_cmd_valid, cfu_rsp_ready, out_valid, err, fid, cin0, cin1, out_result, out_count} !== '0) begin
            n_err++;
            $display("FAIL %s: got rdy=%0b cv=%0b rr=%0b ov=%0b err=%0b fid=%0h i0=%0h i1=%0h res=%0h cnt=%0d want all 0",
                     name, in_ready, cfu_cmd_valid, cfu_rsp_ready, out_valid, err, fid, cin0, cin1, out_result, out_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_basic();
        cmd_stall = 0; rsp_delay = 0;
        add_pair(32'd2, 32'd3); add_pair(32'd4, 32'd5); add_pair(32'd6, 32'd7);
        run_job("basic", 32'd68, TB_CNT_W'(3));
    endtask

    task automatic test_backpressure();
        cmd_stall = 5; rsp_delay = 3;
        add_pair(32'd2, 32'd3); add_pair(32'd4, 32'd5); add_pair(32'd6, 32'd7);
        run_job("backpressure", 32'd68, TB_CNT_W'(3));
        cmd_stall = 0; rsp_delay = 0;
    endtask

    task automatic test_back_to_back();
        add_pair(32'd1, 32'd1);
        run_job("b2b_job1", 32'd1, TB_CNT_W'(1));
        add_pair(32'd10, 32'd10); add_pair(32'hFFFF_FFFF, 32'd2);
        run_job("b2b_job2", 32'd98, TB_CNT_W'(2));
    endtask

    task automatic test_wrap();
        add_pair(32'h0001_0000, 32'h0001_0000);
        run_job("wrap", 32'd0, TB_CNT_W'(1));
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) add_pair(32'd1, 32'd1);
        run_job("saturate", 32'd9, TB_CNT_W'(7));
    endtask

    task automatic test_reset_mid_job();
        int guard;
        add_pair(32'd5, 32'd5);
        run_job("pre_reset", 32'd25, TB_CNT_W'(1));   // leaves a nonzero out_result behind
        cmd_log.delete();
        rsp_delay = 6;
        drive_pair(32'd2, 32'd3, 1'b0);
        guard = 0;
        while (!(cfu_rsp_ready === 1'b1 && cmd_log.size() == 2) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (cfu_rsp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_job_mac_wait: got rsp_ready=%0b want 1", cfu_rsp_ready);
        end
        reset = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_job_reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        abort     = 1'b0;
        rsp_delay = 0;
        add_pair(32'd3, 32'd3);
        run_job("after_reset", 32'd9, TB_CNT_W'(1));
    endtask

    task automatic test_spurious_rsp();
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_before_spur: got %0b want 0", err);
        end
        spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL err_set: got %0b want 1", err);
        end
        add_pair(32'd3, 32'd4); add_pair(32'd5, 32'd6);
        run_job("after_spur", 32'd42, TB_CNT_W'(2));
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got %0b want 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_saturation();
        test_reset_mid_job();
        test_spurious_rsp();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cfu_mac_sequencer.md
Name: cfu_mac_sequencer

Overview:
- Upstream driver for the multiply/accumulate CFU.
- Consumes a stream of signed or unsigned 32-bit operand pairs, one dot-product job per stream packet (terminated by in_last). Drives the CFU over its cmd/rsp handshake: first a clear-accumulator command, then one MAC command per pair.
- Returns the final accumulator value and beat count on a result handshake.
- Sits between the convolution operand fetch logic and the CFU; keeps exactly one CFU command outstanding.

Parameters:
- CNT_W, 16, width of the beat counter and of out_count; the counter saturates at 2^CNT_W-1.
- FID_CLEAR, 10'h00B, function_id for the clear command (op 3, upper bits 7'h01).
- FID_MAC, 10'h003, function_id for the accumulate command (op 3, upper bits 0).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid & in_ready.
- in_a  in  32  operand 0.
- in_b  in  32  operand 1.
- in_last  in  1  final pair of the job.
- cfu_cmd_valid  out  1  command valid to CFU.
- cfu_cmd_ready  in  1  CFU accepts command.
- cfu_cmd_function_id  out  10  command function id.
- cfu_cmd_inputs_0  out  32  command operand 0.
- cfu_cmd_inputs_1  out  32  command operand 1.
- cfu_rsp_valid  in  1  CFU response valid.
- cfu_rsp_ready  out  1  response accepted.
- cfu_rsp_outputs_0  in  32  CFU result.
- out_valid  out  1  job result valid.
- out_ready  in  1  job result consumed.
- out_result  out  32  final accumulator value.
- out_count  out  CNT_W  pairs consumed in the job.
- err_unexpected_rsp  out  1  sticky: cfu_rsp_valid seen outside a WAIT state.

Behaviour:
- Single clock domain; all state updates on posedge clk. Reset is synchronous, active-high, and has priority over all other events.
- Reset values:
  - state = IDLE.
  - in_ready, cfu_cmd_valid, cfu_rsp_ready, out_valid, err_unexpected_rsp = 0.
  - out_result = 0, out_count = 0.
  - Command payload registers = 0.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- States and transitions:
  - IDLE: in_ready=0. If in_valid=1 → CLR_ISSUE. The pair is not consumed. Counter is cleared to 0.
  - CLR_ISSUE: cfu_cmd_valid=1, function_id=FID_CLEAR, inputs_0=inputs_1=0. On cfu_cmd_ready=1 → CLR_WAIT.
  - CLR_WAIT: cfu_rsp_ready=1. On cfu_rsp_valid=1 → FETCH. The response value is discarded.
  - FETCH: in_ready=1. On in_valid=1:
    - latch in_a, in_b and in_last;
    - counter += 1, saturating;
    - → MAC_ISSUE.
  - MAC_ISSUE: cfu_cmd_valid=1, function_id=FID_MAC, inputs = latched pair. On cfu_cmd_ready=1 → MAC_WAIT.
  - MAC_WAIT: cfu_rsp_ready=1. On cfu_rsp_valid=1:
    - if latched last=1: out_result <= cfu_rsp_outputs_0, out_count <= counter, → DONE;
    - else → FETCH.
  - DONE: out_valid=1; out_result and out_count held stable. On out_ready=1 → IDLE.
- Handshake rules:
  - Once cfu_cmd_valid rises, it and the payload stay constant until the cycle cfu_cmd_ready=1.
  - Never more than one CFU command outstanding.
  - Minimum per-pair cost is 3 cycles: FETCH, ISSUE, WAIT with zero-wait CFU.
  - The CFU may hold cfu_cmd_ready or cfu_rsp_valid low for any number of cycles; the FSM waits indefinitely.
- A cfu_rsp_valid pulse in any state other than CLR_WAIT/MAC_WAIT sets err_unexpected_rsp. The flag clears only on reset and has no effect on the FSM.
- A job always contains at least one pair; in_last on the first pair gives a 1-beat job.
- Counter saturation: at 2^CNT_W-1 further beats do not wrap; out_count reports the saturated value.
- Arithmetic is done entirely by the CFU, so results wrap modulo 2^32 as the CFU produces them.
- in_last with in_valid=0 is ignored.
- Reset mid-job: FSM returns to IDLE and the partial job is lost. The next job starts with a clear command, so no stale accumulation carries over.

Test Plan:
- Single job of pairs (2,3),(4,5),(6,7), last on third; CFU always ready, 1-cycle response. Required response:
  - exactly 4 CFU commands in order: clear, MAC(2,3), MAC(4,5), MAC(6,7);
  - out_result=68, out_count=3;
  - out_valid held until out_ready.
- Backpressure: CFU holds cmd_ready low 5 cycles and delays rsp_valid 3 cycles on each command. Required response: payload stable while valid is held, no duplicate commands, same result 68.
- Two back-to-back jobs: first (1,1) last, second (10,10),(−1 as 32'hFFFFFFFF,2) last. Required response: results 1 then 98, counts 1 then 2; second job begins with a clear command.
- Wrap: single pair (32'h0001_0000, 32'h0001_0000) last → out_result = 0 (modulo 2^32).
- Reset asserted during MAC_WAIT of a 3-pair job, then a new job (3,3) last. Required response: all outputs at reset values the cycle after reset; new result 9, count 1.
- Spurious cfu_rsp_valid pulse in IDLE → err_unexpected_rsp=1 and stays 1 across a subsequent normal job, which still completes correctly.
